// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: state encoding, parameter defaults
// and the 16-bit carry-lookahead adder used for the sequential PC increment.
package fetch_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HALT = 2'b10,
        ST_ERR  = 2'b11
    } fetch_state_e;

    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam logic [15:0] DEF_PC_INC   = 16'd2;

    // Four 4-bit lookahead groups with a second lookahead level across groups.
    // The carry out of bit 15 is dropped, so the sum wraps modulo 2^16.
    function automatic logic [15:0] cla_add16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        logic [15:0] g;
        logic [15:0] c;
        logic [2:0]  gg;
        logic [2:0]  gp;
        logic [3:0]  gc;
        p = a ^ b;
        g = a & b;
        for (int k = 0; k < 3; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc[0] = 1'b0;
        gc[1] = gg[0];
        gc[2] = gg[1] | (gp[1] & gg[0]);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]);
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
        return p ^ c;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_pc_reg.sv
// 16-bit PC register with asynchronous active-low reset to a parameterised value
// and a write enable; the register holds whenever we_i is low.
module pc_reg_16b #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [15:0] d_i,
    output logic [15:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RESET_VAL;
        end else if (we_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: picks sequential, redirect or held PC each cycle, parks a
// redirect that arrives while instruction memory is busy, and raises flush for wrong-path work.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEF_RESET_PC,
    parameter logic [15:0] PC_INC   = DEF_PC_INC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        imem_busy_i,
    input  logic        branch_take_i,
    input  logic [15:0] br_addr_i,
    input  logic        jump_i,
    input  logic [15:0] jump_addr_i,
    input  logic        halt_i,
    input  logic        addr_err_i,
    output logic [15:0] pc_o,
    output logic [15:0] pc_plus_o,
    output logic        fetch_en_o,
    output logic        flush_o,
    output logic        halted_o,
    output logic        err_o
);

    fetch_state_e state_q, state_d;
    logic         pend_valid_q, pend_valid_d;
    logic [15:0]  pend_addr_q, pend_addr_d;
    logic         err_q, err_d;

    logic         pc_we;
    logic [15:0]  pc_d;
    logic [15:0]  pc_q;
    logic         redirect;
    logic [15:0]  target;

    assign redirect  = branch_take_i | jump_i;
    assign target    = jump_i ? jump_addr_i : br_addr_i;
    assign pc_plus_o = cla_add16(pc_q, PC_INC);

    pc_reg_16b #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (pc_we),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        err_d        = err_q;
        pc_we        = 1'b0;
        pc_d         = pc_plus_o;
        flush_o      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (addr_err_i) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    flush_o = 1'b1;
                end else if (halt_i) begin
                    state_d = ST_HALT;
                    flush_o = 1'b1;
                end else if (redirect) begin
                    // Redirect beats stall: the stalled instruction is on the wrong path.
                    flush_o = 1'b1;
                    if (imem_busy_i) begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = target;
                        state_d      = ST_WAIT;
                    end else begin
                        pc_we = 1'b1;
                        pc_d  = target;
                    end
                end else if (imem_busy_i) begin
                    state_d = ST_WAIT;
                end else if (!stall_i) begin
                    pc_we = 1'b1;
                end
            end

            ST_WAIT: begin
                if (addr_err_i) begin
                    state_d      = ST_ERR;
                    err_d        = 1'b1;
                    flush_o      = 1'b1;
                    pend_valid_d = 1'b0;
                end else if (halt_i) begin
                    state_d      = ST_HALT;
                    flush_o      = 1'b1;
                    pend_valid_d = 1'b0;
                end else if (redirect) begin
                    flush_o = 1'b1;
                    if (imem_busy_i) begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = target;
                    end else begin
                        pc_we        = 1'b1;
                        pc_d         = target;
                        pend_valid_d = 1'b0;
                        state_d      = ST_RUN;
                    end
                end else if (!imem_busy_i) begin
                    state_d = ST_RUN;
                    if (pend_valid_q) begin
                        pc_we        = 1'b1;
                        pc_d         = pend_addr_q;
                        pend_valid_d = 1'b0;
                    end else if (!stall_i) begin
                        pc_we = 1'b1;
                    end
                end
            end

            default: begin
                // HALT and ERROR are terminal until reset; every input is ignored.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 16'h0000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            err_q        <= err_d;
        end
    end

    assign pc_o       = pc_q;
    assign fetch_en_o = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign halted_o   = (state_q == ST_HALT);
    assign err_o      = err_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed-vector bench for fetch_pc_ctrl; expected values are hand-computed per step.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, imem_busy_i, branch_take_i, jump_i, halt_i, addr_err_i;
    logic [15:0] br_addr_i, jump_addr_i;
    logic [15:0] pc_o, pc_plus_o;
    logic        fetch_en_o, flush_o, halted_o, err_o;

    int n_vec = 0;
    int n_err = 0;

    fetch_pc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .imem_busy_i   (imem_busy_i),
        .branch_take_i (branch_take_i),
        .br_addr_i     (br_addr_i),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .halt_i        (halt_i),
        .addr_err_i    (addr_err_i),
        .pc_o          (pc_o),
        .pc_plus_o     (pc_plus_o),
        .fetch_en_o    (fetch_en_o),
        .flush_o       (flush_o),
        .halted_o      (halted_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("vec %0d %s: %h ok", n_vec, tag, got);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        stall_i = 0; imem_busy_i = 0; branch_take_i = 0; jump_i = 0;
        halt_i = 0; addr_err_i = 0; br_addr_i = 16'h0; jump_addr_i = 16'h0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        check("rst_pc", pc_o, 16'h0000);
        check("rst_err", {15'b0, err_o}, 16'h0);
        check("rst_halted", {15'b0, halted_o}, 16'h0);
        check("rst_flush", {15'b0, flush_o}, 16'h0);
        tick();
        rst_n = 1;
        #1;
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Free-running sequential fetch after reset release.
        for (int i = 0; i < 4; i++) begin
            check("seq_pc", pc_o, 16'(2 * i));
            check("seq_flush", {15'b0, flush_o}, 16'h0);
            check("seq_fetch_en", {15'b0, fetch_en_o}, 16'h1);
            tick();
        end
        check("pc_plus", pc_plus_o, 16'h000A);
        repeat (4) tick();
        check("pc_at_10", pc_o, 16'h0010);

        // Taken branch.
        branch_take_i = 1; br_addr_i = 16'h0040; #1;
        check("br_flush", {15'b0, flush_o}, 16'h1);
        tick(); clear_inputs(); #1;
        check("br_pc", pc_o, 16'h0040);

        // Jump to 0020, then a plain stall holds it.
        jump_i = 1; jump_addr_i = 16'h0020; tick(); clear_inputs();
        stall_i = 1; #1;
        check("stall_flush", {15'b0, flush_o}, 16'h0);
        tick(); #1;
        check("stall_pc", pc_o, 16'h0020);

        // Jump overrides stall.
        jump_i = 1; jump_addr_i = 16'h0100; #1;
        check("stjmp_flush", {15'b0, flush_o}, 16'h1);
        tick(); clear_inputs(); #1;
        check("stjmp_pc", pc_o, 16'h0100);

        // Jump wins over a simultaneous branch.
        branch_take_i = 1; br_addr_i = 16'h0200; jump_i = 1; jump_addr_i = 16'h0300;
        tick(); clear_inputs(); #1;
        check("jmp_wins_pc", pc_o, 16'h0300);

        // Redirects while memory busy: latest pending target wins.
        imem_busy_i = 1; branch_take_i = 1; br_addr_i = 16'h0080; #1;
        check("busy1_flush", {15'b0, flush_o}, 16'h1);
        tick();
        branch_take_i = 0; jump_i = 1; jump_addr_i = 16'h0090; #1;
        check("busy1_pc", pc_o, 16'h0300);
        check("busy2_flush", {15'b0, flush_o}, 16'h1);
        check("busy2_fetch_en", {15'b0, fetch_en_o}, 16'h1);
        tick();
        jump_i = 0; #1;
        check("busy2_pc", pc_o, 16'h0300);
        check("busy3_flush", {15'b0, flush_o}, 16'h0);
        tick(); #1;
        check("busy3_pc", pc_o, 16'h0300);
        imem_busy_i = 0;
        tick(); #1;
        check("pend_pc", pc_o, 16'h0090);
        tick(); #1;
        check("pend_cleared_pc", pc_o, 16'h0092);

        // Redirect in the same cycle memory stops being busy.
        imem_busy_i = 1; tick();
        imem_busy_i = 0; branch_take_i = 1; br_addr_i = 16'h0500; #1;
        check("drop_flush", {15'b0, flush_o}, 16'h1);
        tick(); clear_inputs(); #1;
        check("drop_pc", pc_o, 16'h0500);
        tick(); #1;
        check("drop_next_pc", pc_o, 16'h0502);

        // Busy drop with stall and nothing pending holds PC.
        imem_busy_i = 1; tick();
        imem_busy_i = 0; stall_i = 1; tick(); stall_i = 0; #1;
        check("wait_stall_pc", pc_o, 16'h0502);
        tick(); #1;
        check("wait_stall_next", pc_o, 16'h0504);

        // Wrap FFFE -> 0000.
        jump_i = 1; jump_addr_i = 16'hFFFE; tick(); clear_inputs(); #1;
        check("pc_fffe", pc_o, 16'hFFFE);
        check("pc_plus_wrap", pc_plus_o, 16'h0000);
        tick(); #1;
        check("wrap_pc", pc_o, 16'h0000);
        check("wrap_err", {15'b0, err_o}, 16'h0);

        // Halt freezes PC and ignores redirects.
        halt_i = 1; #1;
        check("halt_flush", {15'b0, flush_o}, 16'h1);
        tick(); clear_inputs();
        jump_i = 1; jump_addr_i = 16'h1234; #1;
        check("halted", {15'b0, halted_o}, 16'h1);
        check("halt_fetch_en", {15'b0, fetch_en_o}, 16'h0);
        check("halt_ign_flush", {15'b0, flush_o}, 16'h0);
        tick(); clear_inputs(); #1;
        check("halt_pc", pc_o, 16'h0000);

        // Reset mid-wait discards the pending target.
        do_reset();
        imem_busy_i = 1; branch_take_i = 1; br_addr_i = 16'h0700;
        tick(); clear_inputs(); #1;
        do_reset();
        tick(); #1;
        check("rst_wait_pc", pc_o, 16'h0002);

        // Address error: sticky, frozen, ignores halt/redirect.
        addr_err_i = 1; #1;
        check("err_flush", {15'b0, flush_o}, 16'h1);
        tick(); clear_inputs();
        halt_i = 1; jump_i = 1; jump_addr_i = 16'h4444; #1;
        check("err_set", {15'b0, err_o}, 16'h1);
        check("err_fetch_en", {15'b0, fetch_en_o}, 16'h0);
        check("err_ign_flush", {15'b0, flush_o}, 16'h0);
        tick(); tick(); clear_inputs(); #1;
        check("err_pc", pc_o, 16'h0002);
        check("err_sticky", {15'b0, err_o}, 16'h1);
        check("err_not_halted", {15'b0, halted_o}, 16'h0);

        // Asynchronous reset takes effect without a clock edge.
        #1 rst_n = 0; #1;
        check("async_pc", pc_o, 16'h0000);
        check("async_err", {15'b0, err_o}, 16'h0);
        rst_n = 1;
        tick(); #1;
        check("post_async_pc", pc_o, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Owns the architectural PC register and sequences fetch for the pipelined processor.
- Selects each cycle between sequential PC+2, the branch target, the jump target, or holding the PC. Selection depends on redirects from the execute stage, hazard stalls, instruction-memory busy, halt and error.
- Buffers a redirect that arrives while instruction memory is busy.
- Generates the pipeline flush for wrong-path instructions.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_INC, 16'd2, sequential increment in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  load-use hazard from decode: hold PC and IF/ID.
- imem_busy  in  1  instruction memory cannot accept a fetch this cycle.
- branch_take  in  1  execute-stage branch resolved taken.
- br_addr  in  16  branch target.
- jump  in  1  execute-stage jump (J/JAL/JR/JALR).
- jump_addr  in  16  jump target.
- halt  in  1  HALT instruction reached execute.
- addr_err  in  1  target-calculation overflow from execute.
- pc  out  16  current fetch address.
- pc_plus  out  16  pc + PC_INC, truncated to 16 bits; feeds link and branch adders.
- fetch_en  out  1  instruction memory read enable.
- flush  out  1  squash IF/ID and ID/EX this cycle.
- halted  out  1  PC frozen by HALT.
- err  out  1  sticky error.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=RUN, pend_valid=0, pend_addr=0.
  - halted=0, err=0, flush=0.
  - fetch_en=1 from the first clock after release.
- States: RUN, WAIT_MEM, HALT, ERROR.
- redirect = branch_take|jump. The target is jump_addr if jump=1, else br_addr. If both are asserted, jump wins.
- RUN, priority high to low, evaluated each cycle:
  1. addr_err=1 → next state ERROR, err<=1, flush=1, pc holds.
  2. halt=1 → next state HALT, flush=1, pc holds.
  3. redirect with imem_busy=0 → pc<=target, flush=1 (combinational, same cycle).
  4. redirect with imem_busy=1 → pend_valid<=1, pend_addr<=target, flush=1, next state WAIT_MEM, pc holds.
  5. imem_busy=1 (no redirect) → next state WAIT_MEM, pc holds.
  6. stall=1 → pc holds.
  7. Otherwise → pc<=pc+PC_INC, wrapping 16'hFFFE→16'h0000 with no error.
- Redirect overrides stall: the stalled instruction is younger and is being flushed.
- WAIT_MEM:
  - fetch_en=1 and pc holds.
  - A redirect while waiting overwrites pend_addr; the latest one wins and flush=1.
  - addr_err or halt: same effect as in RUN, and pend_valid is cleared.
  - When imem_busy=0: if pend_valid, pc<=pend_addr and pend_valid<=0; else pc<=pc+PC_INC unless stall=1. Next state RUN.
  - Redirect in the same cycle imem_busy drops: pc<=target directly, pend_valid<=0.
- HALT:
  - halted=1, fetch_en=0, pc frozen.
  - All inputs are ignored except reset.
- ERROR:
  - err=1, fetch_en=0, pc frozen; exit only via reset.
  - err is sticky.
- flush is high only in the cycle the causing event is sampled. It is never high in HALT/ERROR after entry.
- fetch_en=1 in RUN and WAIT_MEM.
- pc_plus is combinational from pc.
- Reset asserted mid-WAIT_MEM discards the pending target.

Decomposition:
- Shared package holds:
  - state encoding constants ST_RUN=2'b00, ST_WAIT=2'b01, ST_HALT=2'b10, ST_ERR=2'b11;
  - the RESET_PC default;
  - the PC_INC default.
- One sub-module: pc_reg_16b, a 16-bit register with async active-low reset to RESET_PC and a write enable.
- The PC+2 adder reuses the existing 16-bit CLA.

Test Plan:
- Reset release with no stalls for 4 cycles → pc=0000,0002,0004,0006; flush=0; fetch_en=1.
- pc=0010, branch_take=1, br_addr=0040 → flush=1 that cycle; next pc=0040.
- pc=0020, stall=1 and jump=1, jump_addr=0100 in the same cycle → flush=1; next pc=0100.
- imem_busy=1 for 3 cycles, branch to 0080 in cycle 1, then jump to 0090 in cycle 2 → pc holds at its old value throughout; after busy drops pc=0090 and pend_valid=0.
- pc=FFFE, no events → next pc=0000, err=0.
- addr_err=1 → flush=1, err=1 sticky, fetch_en=0, pc frozen; subsequent halt or redirect has no effect. Asserting rst=0 asynchronously → pc=RESET_PC, err=0 immediately.
